// File: rtl/jtag_pkg.sv
// Shared JTAG instruction-path constants: opcodes, default IDCODE and IR capture pattern.
// Opcodes are stored 32 bits wide and truncated to IR_WIDTH by the users.
package jtag_pkg;

   localparam logic [31:0] OP_EXTEST         = 32'h0000_0000;
   localparam logic [31:0] OP_IDCODE         = 32'h0000_0001;
   localparam logic [31:0] OP_SAMPLE_PRELOAD = 32'h0000_0002;
   localparam logic [31:0] OP_BYPASS         = 32'hFFFF_FFFF;

   localparam logic [31:0] DEFAULT_IDCODE    = 32'h1000_0001;
   localparam logic [31:0] IR_CAPTURE        = 32'h0000_0001;

endpackage

// File: rtl/jtag_idcode_reg.sv
// 32-bit IDCODE data register: parallel capture, LSB-first serial shift, gated by enable.
module jtag_idcode_reg #(
   parameter logic [31:0] CAPTURE_VAL = 32'h1000_0001
) (
   input  logic tck,
   input  logic reset,
   input  logic enable,
   input  logic capture,
   input  logic shift,
   input  logic tdi,
   output logic serialOut
);

   logic [31:0] shiftReg;

   always_ff @(posedge tck or posedge reset) begin
      if (reset) begin
         shiftReg <= CAPTURE_VAL;
      end else if (enable) begin
         if (capture) begin
            shiftReg <= CAPTURE_VAL;
         end else if (shift) begin
            shiftReg <= {tdi, shiftReg[31:1]};
         end
      end
   end

   assign serialOut = shiftReg[0];

endmodule

// File: rtl/jtag_ir_dr_path.sv
// JTAG instruction register, decode, bypass/IDCODE data registers and negedge TDO retimer.
// Define JTAG_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module jtag_ir_dr_path
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH   = 4,
   parameter logic [31:0] IDCODE_VAL = DEFAULT_IDCODE
) (
   input  logic                tck,
   input  logic                reset,
   input  logic                tdi,
   // TAP strobes: each is high for the entire tck cycle spent in its state and
   // acts at the posedge that ends that cycle.
   input  logic                captureIR,
   input  logic                shiftIR,
   input  logic                updateIR,
   input  logic                captureDR,
   input  logic                shiftDR,
   input  logic                updateDR,
   input  logic                select,
   input  logic                tdo_en,
   input  logic                bsr_tdo,
   output logic                tdo,
   output logic                tdo_oe,
   output logic [IR_WIDTH-1:0] instr,
   output logic                extest,
   output logic                sample_preload,
   output logic                bypass_sel,
   output logic                idcode_sel
);

   localparam logic [IR_WIDTH-1:0] opExtest    = OP_EXTEST[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] opSample    = OP_SAMPLE_PRELOAD[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] opBypass    = OP_BYPASS[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] irCapture   = IR_CAPTURE[IR_WIDTH-1:0];
`ifdef JTAG_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] opIdcode    = OP_IDCODE[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] instrReset  = opIdcode;
`else
   localparam logic [IR_WIDTH-1:0] instrReset  = opBypass;
`endif

   logic [IR_WIDTH-1:0] irSr;
   logic                bypassBit;
   logic                idcodeBit;
   logic                serialBit;

   always_ff @(posedge tck or posedge reset) begin
      if (reset) begin
         irSr <= '0;
      end else if (captureIR) begin
         irSr <= irCapture;
      end else if (shiftIR) begin
         irSr <= {tdi, irSr[IR_WIDTH-1:1]};
      end
   end

   always_ff @(posedge tck or posedge reset) begin
      if (reset) begin
         instr <= instrReset;
      end else if (updateIR) begin
         instr <= irSr;
      end
   end

   // Unlisted opcodes fall through to BYPASS so exactly one select is high.
   always_comb begin
      extest         = 1'b0;
      sample_preload = 1'b0;
      idcode_sel     = 1'b0;
      bypass_sel     = 1'b0;
      if (instr == opExtest) begin
         extest = 1'b1;
      end else if (instr == opSample) begin
         sample_preload = 1'b1;
`ifdef JTAG_IDCODE_EN
      end else if (instr == opIdcode) begin
         idcode_sel = 1'b1;
`endif
      end else begin
         bypass_sel = 1'b1;
      end
   end

   always_ff @(posedge tck or posedge reset) begin
      if (reset) begin
         bypassBit <= 1'b0;
      end else if (bypass_sel) begin
         if (captureDR) begin
            bypassBit <= 1'b0;
         end else if (shiftDR) begin
            bypassBit <= tdi;
         end
      end
   end

`ifdef JTAG_IDCODE_EN
   jtag_idcode_reg #(
      .CAPTURE_VAL (IDCODE_VAL)
   ) u_idcode (
      .tck       (tck),
      .reset     (reset),
      .enable    (idcode_sel),
      .capture   (captureDR),
      .shift     (shiftDR),
      .tdi       (tdi),
      .serialOut (idcodeBit)
   );

   logic unusedInputs;
   assign unusedInputs = &{1'b0, updateDR};
`else
   assign idcodeBit = 1'b0;

   logic unusedInputs;
   assign unusedInputs = &{1'b0, updateDR, IDCODE_VAL};
`endif

   always_comb begin
      serialBit = bsr_tdo;
      if (select) begin
         serialBit = irSr[0];
      end else if (idcode_sel) begin
         serialBit = idcodeBit;
      end else if (bypass_sel) begin
         serialBit = bypassBit;
      end
   end

   // Negedge retiming gives the downstream device a half cycle of setup before its posedge.
   always_ff @(negedge tck or posedge reset) begin
      if (reset) begin
         tdo    <= 1'b0;
         tdo_oe <= 1'b0;
      end else begin
         tdo    <= serialBit;
         tdo_oe <= tdo_en;
      end
   end

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Self-checking bench for jtag_ir_dr_path: scoreboard of expected tdo bits popped by a monitor,
// plus direct decode/reset checks. Honours JTAG_IDCODE_EN the same way as the design.
module tb_jtag_ir_dr_path;

   localparam int          W        = 4;
   localparam logic [31:0] IDCODE_V = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
   localparam bit          idcodeEn = 1'b1;
   localparam logic [W-1:0] resetInstr = 4'b0001;
`else
   localparam bit          idcodeEn = 1'b0;
   localparam logic [W-1:0] resetInstr = 4'b1111;
`endif

   logic         tck = 1'b0;
   logic         reset;
   logic         tdi;
   logic         captureIR, shiftIR, updateIR;
   logic         captureDR, shiftDR, updateDR;
   logic         select, tdo_en, bsr_tdo;
   logic         tdo, tdo_oe;
   logic [W-1:0] instr;
   logic         extest, sample_preload, bypass_sel, idcode_sel;

   logic [0:0]   exp_q[$];
   bit           irQ[$];
   bit           drQ[$];
   logic [W-1:0] modelInstr;
   int           nChecks = 0;
   int           nFails  = 0;

   jtag_ir_dr_path #(
      .IR_WIDTH   (W),
      .IDCODE_VAL (IDCODE_V)
   ) dut (
      .tck            (tck),
      .reset          (reset),
      .tdi            (tdi),
      .captureIR      (captureIR),
      .shiftIR        (shiftIR),
      .updateIR       (updateIR),
      .captureDR      (captureDR),
      .shiftDR        (shiftDR),
      .updateDR       (updateDR),
      .select         (select),
      .tdo_en         (tdo_en),
      .bsr_tdo        (bsr_tdo),
      .tdo            (tdo),
      .tdo_oe         (tdo_oe),
      .instr          (instr),
      .extest         (extest),
      .sample_preload (sample_preload),
      .bypass_sel     (bypass_sel),
      .idcode_sel     (idcode_sel)
   );

   // Clock and watchdog
   always #5 tck = ~tck;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d expected bits pending", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   // Reference decode: {extest, sample_preload, idcode_sel, bypass_sel}
   function automatic logic [3:0] expSel(input logic [W-1:0] op);
      logic ex, sp, id;
      ex = (op == 4'd0);
      sp = (op == 4'd2);
      id = idcodeEn && (op == 4'd1);
      return {ex, sp, id, !(ex || sp || id)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkDecode(input string tag);
      logic [3:0] s;
      s = expSel(modelInstr);
      check({tag, "_instr"},          instr,          modelInstr);
      check({tag, "_extest"},         extest,         s[3]);
      check({tag, "_sample_preload"}, sample_preload, s[2]);
      check({tag, "_idcode_sel"},     idcode_sel,     s[1]);
      check({tag, "_bypass_sel"},     bypass_sel,     s[0]);
   endtask

   // Monitor: whenever tdo is enabled, the bit on tdo must match the scoreboard head.
   always @(posedge tck) begin
      if (!reset && tdo_oe === 1'b1) begin
         if (exp_q.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL tdo_unexpected: got %b with no expected bit queued", tdo);
         end else begin
            logic [0:0] e;
            e = exp_q.pop_front();
            nChecks++;
            if (tdo !== e) begin
               nFails++;
               $display("FAIL tdo_stream: got %b expected %b", tdo, e);
            end
         end
      end
   end

   // Driver tasks
   task automatic cycle();
      @(posedge tck);
      #1;
   endtask

   task automatic loadIr(input logic [W-1:0] val);
      logic [W-1:0] oldInstr;
      oldInstr = modelInstr;
      select = 1'b1;
      captureIR = 1'b1;
      cycle();
      captureIR = 1'b0;
      irQ.delete();
      for (int i = 0; i < W; i++) irQ.push_back(i == 0);
      shiftIR = 1'b1;
      tdo_en  = 1'b1;
      for (int i = 0; i < W; i++) begin
         tdi = val[i];
         exp_q.push_back(irQ.pop_front());
         irQ.push_back(val[i]);
         check("instr_hold", instr, oldInstr);
         cycle();
      end
      shiftIR = 1'b0;
      tdo_en  = 1'b0;
      cycle();
      check("instr_hold_exit", instr, oldInstr);
      updateIR = 1'b1;
      cycle();
      updateIR = 1'b0;
      select   = 1'b0;
      for (int i = 0; i < W; i++) modelInstr[i] = irQ[i];
      checkDecode("update");
   endtask

   task automatic runDr(input int n, input logic [63:0] pat);
      logic [3:0] s;
      bit bsrPath;
      s = expSel(modelInstr);
      bsrPath = s[3] || s[2];
      captureDR = 1'b1;
      cycle();
      captureDR = 1'b0;
      drQ.delete();
      if (s[1]) begin
         for (int i = 0; i < 32; i++) drQ.push_back(IDCODE_V[i]);
      end else begin
         drQ.push_back(1'b0);
      end
      shiftDR = 1'b1;
      tdo_en  = 1'b1;
      for (int i = 0; i < n; i++) begin
         tdi     = pat[i];
         bsr_tdo = 1'($urandom_range(0, 1));
         if (bsrPath) begin
            exp_q.push_back(bsr_tdo);
         end else begin
            exp_q.push_back(drQ.pop_front());
            drQ.push_back(pat[i]);
         end
         cycle();
      end
      shiftDR = 1'b0;
      tdo_en  = 1'b0;
      cycle();
      updateDR = 1'b1;
      cycle();
      updateDR = 1'b0;
      check("dr_instr_stable", instr, modelInstr);
   endtask

   // Main sequence
   initial begin
      reset = 1'b1;
      tdi = 1'b0; captureIR = 1'b0; shiftIR = 1'b0; updateIR = 1'b0;
      captureDR = 1'b0; shiftDR = 1'b0; updateDR = 1'b0;
      select = 1'b0; tdo_en = 1'b0; bsr_tdo = 1'b0;
      modelInstr = resetInstr;
      repeat (2) @(posedge tck);
      #1;
      check("reset_tdo", tdo, 1'b0);
      check("reset_tdo_oe", tdo_oe, 1'b0);
      checkDecode("reset");
      reset = 1'b0;
      cycle();

      // Default instruction data register (IDCODE stream, or bypass without the macro)
      runDr(36, {$urandom, $urandom});

      // BYPASS with tdi 1,0,1,1 (then 0) expects tdo 0,1,0,1,1
      loadIr(4'b1111);
      runDr(5, 64'b01101);

      loadIr(4'b0110);
      runDr(8, {$urandom, $urandom});

      loadIr(4'b0000);
      runDr(12, {$urandom, $urandom});

      loadIr(4'b0010);
      runDr(6, {$urandom, $urandom});

      loadIr(4'b0001);
      runDr(34, {$urandom, $urandom});

      for (int k = 0; k < 10; k++) begin
         loadIr(4'($urandom_range(0, 15)));
         runDr($urandom_range(1, 40), {$urandom, $urandom});
      end

      // Reset in the middle of Shift-IR
      loadIr(4'b0000);
      select = 1'b1;
      captureIR = 1'b1;
      cycle();
      captureIR = 1'b0;
      shiftIR = 1'b1;
      tdo_en  = 1'b1;
      exp_q.push_back(1'b1);
      tdi = 1'b0;
      cycle();
      exp_q.push_back(1'b0);
      tdi = 1'b1;
      cycle();
      reset = 1'b1;
      #1;
      modelInstr = resetInstr;
      check("midreset_tdo_oe", tdo_oe, 1'b0);
      check("midreset_tdo", tdo, 1'b0);
      checkDecode("midreset");
      shiftIR = 1'b0;
      tdo_en  = 1'b0;
      select  = 1'b0;
      cycle();
      reset = 1'b0;
      cycle();
      checkDecode("after_reset");
      runDr(10, {$urandom, $urandom});
      loadIr(4'b0010);
      runDr(4, {$urandom, $urandom});

      repeat (2) cycle();
      check("queue_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/jtag_ir_dr_path.md
# jtag_ir_dr_path

Instruction register, instruction decode, bypass and IDCODE data registers, and the TDO output retimer, all clocked by `tck`. The block sits directly downstream of the TAP controller and consumes its capture/shift/update strobes, `select` and `tdo_en`. It drives device TDO and hands decoded instruction selects to the boundary-scan chain.

## Interface
- `IR_WIDTH`, 4: instruction register length, minimum 2.
- `IDCODE_VAL`, 32'h1000_0001: IDCODE capture value. Bit 0 must be 1.
- `tck`, in, 1: test clock. Registers use posedge; the TDO retimer uses negedge.
- `reset`, in, 1: asynchronous, active-high; clears every register.
- `tdi`, in, 1: serial test data in.
- `captureIR`, `shiftIR`, `updateIR`, in, 1 each: TAP state decodes, each high for the whole tck cycle spent in its state.
- `captureDR`, `shiftDR`, `updateDR`, in, 1 each: TAP state decodes, same convention.
- `select`, in, 1: 1 = IR path to TDO, 0 = DR path.
- `tdo_en`, in, 1: TAP is in Shift-IR or Shift-DR.
- `bsr_tdo`, in, 1: serial out of the external boundary-scan register.
- `tdo`, out, 1: retimed serial out.
- `tdo_oe`, out, 1: TDO output enable.
- `instr`, out, IR_WIDTH: current (update-stage) instruction.
- `extest`, `sample_preload`, `bypass_sel`, `idcode_sel`, out, 1 each: one-hot instruction decode.

## Operation
- Opcodes:
  - EXTEST = all-zeros.
  - SAMPLE_PRELOAD = 2.
  - IDCODE = 1.
  - BYPASS = all-ones.
  - Any other code decodes as BYPASS, so exactly one select is always high.
- IR shift register `ir_sr`, IR_WIDTH bits, posedge tck:
  - captureIR: load IR_WIDTH'b...0001 (bit0 = 1, bit1 = 0, upper bits 0).
  - shiftIR: `ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]}`, LSB first.
  - Otherwise hold.
- IR update register `instr`:
  - Loads `ir_sr` on the posedge at which `updateIR` = 1.
  - Otherwise holds; it never changes during shifting.
- Bypass register, 1 bit:
  - captureDR && bypass_sel: load 0.
  - shiftDR && bypass_sel: load `tdi`.
- IDCODE register, 32 bits:
  - captureDR && idcode_sel: load IDCODE_VAL.
  - shiftDR && idcode_sel: shift right, `tdi` into bit 31.
- Serial mux (combinational) selects by priority:
  1. `select` = 1: `ir_sr[0]`.
  2. Else idcode_sel: `idcode_sr[0]`.
  3. Else bypass_sel: bypass bit.
  4. Else (extest / sample_preload): `bsr_tdo`.
- Retimer, negedge tck: `tdo <= mux`; `tdo_oe <= tdo_en`.
- Boundary-scan capture and update belong to the external BSR. This block only supplies the selects.
- `updateDR` has no effect on internal registers; it is accepted for port symmetry.
- Simultaneous strobes (illegal from a conformant TAP) resolve by priority: capture > shift > hold.

## Timing
- Reset values:
  - `ir_sr` = 0.
  - `instr` = IDCODE (per Configuration).
  - Bypass bit = 0.
  - `idcode_sr` = IDCODE_VAL.
  - `tdo` = 0, `tdo_oe` = 0.
- Asynchronous reset asserted mid-shift aborts the shift. The next captureIR/captureDR starts clean.
- Decode outputs change in the same cycle `instr` loads, i.e. one posedge after entering Update-IR.
- `tdo` and `tdo_oe` change only on negedge: half a tck cycle after the posedge that moved the TAP state or shifted data.
  - The first captured bit appears on the negedge inside the first Shift cycle.
- IR round-trip: IR_WIDTH shift cycles move the captured pattern fully out and `tdi` fully in.
- Bypass adds exactly one tck cycle of tdi→tdo delay.

## Configuration
- `JTAG_IDCODE_EN` defined:
  - IDCODE register present.
  - Reset and Test-Logic-Reset instruction = IDCODE.
- Undefined:
  - IDCODE register removed.
  - Opcode 1 decodes as BYPASS and `idcode_sel` is tied 0.
  - Reset instruction = BYPASS (all-ones).

## Structure
- Shared package `jtag_pkg`: opcode localparams (EXTEST, IDCODE, SAMPLE_PRELOAD, BYPASS), default IDCODE_VAL, IR capture pattern.
- One sub-module `jtag_idcode_reg` (capture/shift 32-bit register with enable). Instantiated only under `JTAG_IDCODE_EN`.

## Test plan
- Reset, then read: pulse `reset` → `instr` = 4'b0001, `idcode_sel` = 1, `tdo` = 0, `tdo_oe` = 0.
  - Then Capture-DR plus 32 Shift-DR cycles → `tdo` streams 32'h1000_0001 LSB first, and `tdo_oe` = 1 throughout the shift.
- Select BYPASS: Capture-IR, shift in 4'b1111 → `tdo` emits 1,0,0,0.
  - After Update-IR, `bypass_sel` = 1.
  - Then Shift-DR with tdi pattern 1,0,1,1 → `tdo` shows 0,1,0,1,1 (one-cycle delay).
- Undefined opcode: load 4'b0110 → `bypass_sel` = 1, other selects 0, `instr` = 4'b0110.
- EXTEST path: load 4'b0000 → `extest` = 1. In Shift-DR, toggling `bsr_tdo` appears on `tdo` at the following negedge.
- Instruction stability: during Shift-IR of 4'b0010, `instr` keeps its old value until the Update-IR posedge, then `sample_preload` = 1.
- Reset mid-shift: assert `reset` after 2 of 4 Shift-IR cycles → `instr` returns to IDCODE (BYPASS without the macro), and `tdo_oe` = 0 immediately.
